// File: rtl/crypto_seq_pkg.sv
// rtl/crypto_seq_pkg.sv - sequencer states and LFSR constants shared by crypto_seq_ctrl and lfsr16
package crypto_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_RUN,
    ST_CAPTURE
  } seq_state_t;

  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR used for the jitter pre-delay; a zero seed falls back to LFSR_RESET
module lfsr16
  import crypto_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= LFSR_RESET;
    end else if (load) begin
      q <= (seed == 16'h0000) ? LFSR_RESET : seed;
    end else if (step) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/crypto_seq_ctrl.sv
// rtl/crypto_seq_ctrl.sv - start/load/busy/capture sequencer for the AES core; RANDOM_DELAY_EN adds the LFSR pre-delay
module crypto_seq_ctrl
  import crypto_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] text_i,
  input  logic         seed_load_i,
  input  logic [15:0]  seed_i,
  input  logic [7:0]   delay_mask_i,
  output logic         core_load_o,
  output logic [127:0] core_key_o,
  output logic [127:0] core_data_o,
  input  logic [127:0] core_data_i,
  input  logic         core_busy_i,
  output logic [127:0] cipher_o,
  output logic         ready_o,
  output logic         done_o,
  output logic         timeout_o,
  output logic         trigger_o
);

  seq_state_t      state, state_nxt;
  logic [TO_W-1:0] wdog, wdog_nxt;
  logic            accept;
  logic            wdog_expired;
  logic            set_timeout;

  assign accept       = (state == ST_IDLE) && start_i;
  assign wdog_expired = (wdog == TO_W'(TIMEOUT_CYCLES - 1));
  assign ready_o      = (state == ST_IDLE);

`ifdef RANDOM_DELAY_EN
  logic [15:0] lfsr_q;
  logic [7:0]  dly, dly_nxt;
  logic [7:0]  dly_init;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (accept),
    .load (seed_load_i),
    .seed (seed_i),
    .q    (lfsr_q)
  );

  assign dly_init = lfsr_q[7:0] & delay_mask_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dly <= '0;
    else     dly <= dly_nxt;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{seed_load_i, seed_i, delay_mask_i};
`endif

  always_comb begin
    state_nxt   = state;
    wdog_nxt    = wdog;
    set_timeout = 1'b0;
`ifdef RANDOM_DELAY_EN
    dly_nxt     = dly;
`endif
    case (state)
      ST_IDLE: begin
        if (start_i) begin
`ifdef RANDOM_DELAY_EN
          dly_nxt   = dly_init;
          state_nxt = (dly_init != 8'h00) ? ST_DELAY : ST_LOAD;
`else
          state_nxt = ST_LOAD;
`endif
        end
      end
`ifdef RANDOM_DELAY_EN
      ST_DELAY: begin
        dly_nxt = dly - 8'd1;
        if (dly == 8'd1) state_nxt = ST_LOAD;
      end
`endif
      ST_LOAD: begin
        wdog_nxt  = '0;
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (core_busy_i) begin
          wdog_nxt  = '0;
          state_nxt = ST_RUN;
        end else if (wdog_expired) begin
          set_timeout = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          wdog_nxt = wdog + TO_W'(1);
        end
      end
      ST_RUN: begin
        if (!core_busy_i) begin
          state_nxt = ST_CAPTURE;
        end else if (wdog_expired) begin
          set_timeout = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          wdog_nxt = wdog + TO_W'(1);
        end
      end
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wdog        <= '0;
      core_key_o  <= '0;
      core_data_o <= '0;
      cipher_o    <= '0;
      core_load_o <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      trigger_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      wdog        <= wdog_nxt;
      core_load_o <= (state_nxt == ST_LOAD);
      trigger_o   <= (state_nxt == ST_LOAD) || (state_nxt == ST_WAIT_BUSY) ||
                     (state_nxt == ST_RUN)  || (state_nxt == ST_CAPTURE);
      if (accept) begin
        core_key_o  <= key_i;
        core_data_o <= text_i;
        done_o      <= 1'b0;
        timeout_o   <= 1'b0;
      end
      if (set_timeout) timeout_o <= 1'b1;
      if (state == ST_CAPTURE) begin
        cipher_o <= core_data_i;
        done_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// tb/tb_crypto_seq_ctrl.sv - randomized self-checking bench for crypto_seq_ctrl with a behavioural AES core
module tb_crypto_seq_ctrl;

  localparam int TIMEOUT_CYCLES = 1023;
  localparam int TO_W           = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [127:0] text_i = '0;
  logic         seed_load_i = 1'b0;
  logic [15:0]  seed_i = '0;
  logic [7:0]   delay_mask_i = '0;
  logic         core_load_o;
  logic [127:0] core_key_o;
  logic [127:0] core_data_o;
  logic [127:0] core_data_i = '0;
  logic         core_busy_i = 1'b0;
  logic [127:0] cipher_o;
  logic         ready_o;
  logic         done_o;
  logic         timeout_o;
  logic         trigger_o;

  crypto_seq_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .key_i        (key_i),
    .text_i       (text_i),
    .seed_load_i  (seed_load_i),
    .seed_i       (seed_i),
    .delay_mask_i (delay_mask_i),
    .core_load_o  (core_load_o),
    .core_key_o   (core_key_o),
    .core_data_o  (core_data_o),
    .core_data_i  (core_data_i),
    .core_busy_i  (core_busy_i),
    .cipher_o     (cipher_o),
    .ready_o      (ready_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .trigger_o    (trigger_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int rel      = 0;
  int pulse_at = -1;
  bit hold_start = 1'b0;

  logic [15:0]  m_lfsr  = 16'hACE1;
  logic [127:0] last_ct = '0;
  logic [7:0]   sbox_t [256];

  int           obs_lat, obs_nready, obs_trig_bad, obs_load_pulses;
  logic         obs_done1, obs_to1;
  logic [127:0] obs_key, obs_text;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  task automatic init_sbox;
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
      sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [127:0] st, rk;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) n[4*c+j] = s[4*((c+j)%4)+j];
      for (int c = 0; c < 4; c++) begin
        if (r != 10) begin
          s[4*c]   = xt(n[4*c]) ^ xt(n[4*c+1]) ^ n[4*c+1] ^ n[4*c+2] ^ n[4*c+3];
          s[4*c+1] = n[4*c] ^ xt(n[4*c+1]) ^ xt(n[4*c+2]) ^ n[4*c+2] ^ n[4*c+3];
          s[4*c+2] = n[4*c] ^ n[4*c+1] ^ xt(n[4*c+2]) ^ xt(n[4*c+3]) ^ n[4*c+3];
          s[4*c+3] = xt(n[4*c]) ^ n[4*c] ^ n[4*c+1] ^ n[4*c+2] ^ xt(n[4*c+3]);
        end else begin
          for (int j = 0; j < 4; j++) s[4*c+j] = n[4*c+j];
        end
      end
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = s[i] ^ rk[127-8*i -: 8];
    end
    return st;
  endfunction

  // Feedback mask derived from the polynomial exponents, not copied from the design.
  function automatic logic [15:0] model_step(input logic [15:0] s);
    int exps [4];
    logic [15:0] fb;
    exps = '{16, 14, 13, 11};
    fb = '0;
    for (int i = 0; i < 4; i++) fb[exps[i] - 1] = 1'b1;
    return s[0] ? ((s >> 1) ^ fb) : (s >> 1);
  endfunction

  task automatic model_start(input logic [7:0] mask, output int lat);
`ifdef RANDOM_DELAY_EN
    lat = 1 + int'(m_lfsr[7:0] & mask);
    m_lfsr = model_step(m_lfsr);
`else
    lat = 1 + int'(mask & 8'h00);
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    rel++;
    start_i = hold_start || (rel == pulse_at);
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_i = s;
    seed_load_i = 1'b1;
    tick;
    seed_load_i = 1'b0;
    m_lfsr = (s == 16'h0000) ? 16'hACE1 : s;
  endtask

  // mode 0: busy after bdly WAIT cycles for rlen+1 cycles; 1: busy never; 2: busy stuck high.
  task automatic do_op(input logic [127:0] k, input logic [127:0] t,
                       input int bdly, input int rlen, input int mode);
    logic [127:0] ct;
    key_i = k;
    text_i = t;
    start_i = 1'b1;
    rel = 0;
    core_busy_i = 1'b0;
    tick;
    obs_done1 = done_o;
    obs_to1 = timeout_o;
    obs_lat = 1;
    while (core_load_o !== 1'b1 && obs_lat < 600) begin
      tick;
      obs_lat++;
    end
    obs_key = core_key_o;
    obs_text = core_data_o;
    ct = aes128(core_key_o, core_data_o);
    obs_trig_bad = (trigger_o !== 1'b1) ? 1 : 0;
    obs_nready = 0;
    obs_load_pulses = 0;
    for (int c = 1; c < 2300; c++) begin
      tick;
      if (ready_o === 1'b1) break;
      obs_nready++;
      if (trigger_o !== 1'b1) obs_trig_bad++;
      if (core_load_o !== 1'b0) obs_load_pulses++;
      case (mode)
        0:       core_busy_i = (c >= bdly + 1) && (c <= bdly + 1 + rlen);
        1:       core_busy_i = 1'b0;
        default: core_busy_i = (c >= bdly + 1);
      endcase
      core_data_i = (mode == 0 && c >= bdly + 2 + rlen) ? ct : {$urandom, $urandom, $urandom, $urandom};
    end
    core_busy_i = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b exp 1", ready_o); else n_pass++;
    n_checks++; if (core_load_o !== 1'b0) $display("FAIL reset_load: got %b exp 0", core_load_o); else n_pass++;
    n_checks++; if ({done_o, timeout_o, trigger_o} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {done_o, timeout_o, trigger_o}); else n_pass++;
    n_checks++; if ({cipher_o, core_key_o, core_data_o} !== '0) $display("FAIL reset_data: got %h exp 0", cipher_o ^ core_key_o ^ core_data_o); else n_pass++;
  endtask

  task automatic test_fips;
    logic [127:0] k, p;
    int exp_lat;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    p = 128'h00112233445566778899aabbccddeeff;
    delay_mask_i = 8'h00;
    model_start(delay_mask_i, exp_lat);
    do_op(k, p, 2, 3, 0);
    n_checks++; if (obs_lat !== 1) $display("FAIL fips_latency: got %0d exp 1", obs_lat); else n_pass++;
    n_checks++; if (obs_key !== k || obs_text !== p) $display("FAIL fips_latch: got %h/%h exp %h/%h", obs_key, obs_text, k, p); else n_pass++;
    n_checks++; if (cipher_o !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) $display("FAIL fips_cipher: got %h exp 69c4e0d86a7b0430d8cdb78070b4c55a", cipher_o); else n_pass++;
    n_checks++; if (done_o !== 1'b1 || timeout_o !== 1'b0) $display("FAIL fips_done: got done=%b to=%b exp 1/0", done_o, timeout_o); else n_pass++;
    n_checks++; if (obs_trig_bad !== 0 || trigger_o !== 1'b0) $display("FAIL fips_trigger: got bad=%0d end=%b exp 0/0", obs_trig_bad, trigger_o); else n_pass++;
    n_checks++; if (obs_nready !== 8) $display("FAIL fips_busy_cycles: got %0d exp 8", obs_nready); else n_pass++;
    n_checks++; if (obs_load_pulses !== 0) $display("FAIL fips_load_width: got %0d extra exp 0", obs_load_pulses); else n_pass++;
    last_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  endtask

  task automatic test_random_ops;
    logic [127:0] k, p;
    int exp_lat, bdly, rlen;
    load_seed(16'($urandom));
    for (int i = 0; i < 5; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      bdly = $urandom_range(0, 6);
      rlen = $urandom_range(0, 6);
      delay_mask_i = 8'($urandom_range(0, 15));
      model_start(delay_mask_i, exp_lat);
      do_op(k, p, bdly, rlen, 0);
      last_ct = aes128(k, p);
      n_checks++; if (obs_lat !== exp_lat) $display("FAIL rand_latency[%0d]: got %0d exp %0d", i, obs_lat, exp_lat); else n_pass++;
      n_checks++; if (cipher_o !== last_ct) $display("FAIL rand_cipher[%0d]: got %h exp %h", i, cipher_o, last_ct); else n_pass++;
      n_checks++; if (obs_nready !== bdly + rlen + 3) $display("FAIL rand_busy_cycles[%0d]: got %0d exp %0d", i, obs_nready, bdly + rlen + 3); else n_pass++;
      n_checks++; if ({done_o, timeout_o, trigger_o} !== 3'b100 || obs_trig_bad !== 0) $display("FAIL rand_flags[%0d]: got %b bad=%0d exp 100 bad=0", i, {done_o, timeout_o, trigger_o}, obs_trig_bad); else n_pass++;
    end
  endtask

`ifdef RANDOM_DELAY_EN
  task automatic test_lfsr_seq;
    int exp_lat;
    load_seed(16'h0001);
    delay_mask_i = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      model_start(delay_mask_i, exp_lat);
      do_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
      n_checks++; if (obs_lat !== exp_lat) $display("FAIL lfsr_latency[%0d]: got %0d exp %0d", i, obs_lat, exp_lat); else n_pass++;
    end
  endtask

  task automatic test_mask_zero;
    int exp_lat;
    load_seed(16'($urandom));
    delay_mask_i = 8'h00;
    for (int i = 0; i < 3; i++) begin
      model_start(delay_mask_i, exp_lat);
      do_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 0);
      n_checks++; if (obs_lat !== 1) $display("FAIL mask0_latency[%0d]: got %0d exp 1", i, obs_lat); else n_pass++;
    end
  endtask
`endif

  task automatic test_start_ignored;
    int exp_lat, extra;
    logic [127:0] k, p;
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
`ifdef RANDOM_DELAY_EN
    load_seed(16'h0000);
    delay_mask_i = 8'hFF;
    pulse_at = 5;
`else
    pulse_at = 3;
`endif
    model_start(delay_mask_i, exp_lat);
    do_op(k, p, 4, 2, 0);
    pulse_at = -1;
    last_ct = aes128(k, p);
`ifdef RANDOM_DELAY_EN
    n_checks++; if (obs_lat !== 226) $display("FAIL seed_zero_latency: got %0d exp 226", obs_lat); else n_pass++;
`endif
    n_checks++; if (obs_lat !== exp_lat) $display("FAIL ignored_start_latency: got %0d exp %0d", obs_lat, exp_lat); else n_pass++;
    n_checks++; if (cipher_o !== last_ct) $display("FAIL ignored_start_cipher: got %h exp %h", cipher_o, last_ct); else n_pass++;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (core_load_o !== 1'b0 || ready_o !== 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) $display("FAIL ignored_start_requeue: got %0d busy cycles exp 0", extra); else n_pass++;
    delay_mask_i = 8'h00;
  endtask

  task automatic test_wait_timeout;
    int exp_lat;
    delay_mask_i = 8'h00;
    model_start(delay_mask_i, exp_lat);
    do_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);
    n_checks++; if (obs_done1 !== 1'b0) $display("FAIL wto_done_clear: got %b exp 0", obs_done1); else n_pass++;
    n_checks++; if (obs_nready !== TIMEOUT_CYCLES) $display("FAIL wto_cycles: got %0d exp %0d", obs_nready, TIMEOUT_CYCLES); else n_pass++;
    n_checks++; if ({timeout_o, done_o, trigger_o, ready_o} !== 4'b1001) $display("FAIL wto_flags: got %b exp 1001", {timeout_o, done_o, trigger_o, ready_o}); else n_pass++;
    n_checks++; if (cipher_o !== last_ct) $display("FAIL wto_cipher_kept: got %h exp %h", cipher_o, last_ct); else n_pass++;
  endtask

  task automatic test_run_timeout;
    int exp_lat;
    model_start(delay_mask_i, exp_lat);
    do_op({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 3, 0, 2);
    n_checks++; if (obs_to1 !== 1'b0) $display("FAIL rto_timeout_clear: got %b exp 0", obs_to1); else n_pass++;
    n_checks++; if (obs_nready !== 4 + TIMEOUT_CYCLES) $display("FAIL rto_cycles: got %0d exp %0d", obs_nready, 4 + TIMEOUT_CYCLES); else n_pass++;
    n_checks++; if ({timeout_o, done_o, trigger_o} !== 3'b100) $display("FAIL rto_flags: got %b exp 100", {timeout_o, done_o, trigger_o}); else n_pass++;
    n_checks++; if (cipher_o !== last_ct) $display("FAIL rto_cipher_kept: got %h exp %h", cipher_o, last_ct); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [127:0] k1, p1, k2, p2;
    int exp_lat;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    p1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    hold_start = 1'b1;
    delay_mask_i = 8'($urandom_range(0, 7));
    model_start(delay_mask_i, exp_lat);
    do_op(k1, p1, 1, 1, 0);
    n_checks++; if (cipher_o !== aes128(k1, p1) || done_o !== 1'b1) $display("FAIL b2b_first: got %h done=%b exp %h done=1", cipher_o, done_o, aes128(k1, p1)); else n_pass++;
    model_start(delay_mask_i, exp_lat);
    do_op(k2, p2, 0, 2, 0);
    hold_start = 1'b0;
    start_i = 1'b0;
    last_ct = aes128(k2, p2);
    n_checks++; if (obs_done1 !== 1'b0) $display("FAIL b2b_done_clear: got %b exp 0", obs_done1); else n_pass++;
    n_checks++; if (obs_lat !== exp_lat) $display("FAIL b2b_latency: got %0d exp %0d", obs_lat, exp_lat); else n_pass++;
    n_checks++; if (cipher_o !== last_ct) $display("FAIL b2b_second: got %h exp %h", cipher_o, last_ct); else n_pass++;
    delay_mask_i = 8'h00;
  endtask

  task automatic test_reset_midrun;
    int n, exp_lat;
    logic [127:0] k, p;
    model_start(8'h00, exp_lat);
    key_i = {$urandom, $urandom, $urandom, $urandom};
    text_i = {$urandom, $urandom, $urandom, $urandom};
    start_i = 1'b1;
    rel = 0;
    tick;
    n = 0;
    while (core_load_o !== 1'b1 && n < 600) begin
      tick;
      n++;
    end
    tick;
    core_busy_i = 1'b1;
    tick;
    tick;
    tick;
    n_checks++; if (trigger_o !== 1'b1 || ready_o !== 1'b0) $display("FAIL rst_pre_run: got trig=%b ready=%b exp 1/0", trigger_o, ready_o); else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_checks++; if ({ready_o, trigger_o, core_load_o, done_o, timeout_o} !== 5'b10000) $display("FAIL rst_async_flags: got %b exp 10000", {ready_o, trigger_o, core_load_o, done_o, timeout_o}); else n_pass++;
    n_checks++; if ({cipher_o, core_key_o, core_data_o} !== '0) $display("FAIL rst_async_data: got %h exp 0", cipher_o ^ core_key_o ^ core_data_o); else n_pass++;
    core_busy_i = 1'b0;
    m_lfsr = 16'hACE1;
    @(negedge clk);
    rst = 1'b0;
    tick;
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
`ifdef RANDOM_DELAY_EN
    delay_mask_i = 8'hFF;
`endif
    model_start(delay_mask_i, exp_lat);
    do_op(k, p, 0, 1, 0);
    n_checks++; if (obs_lat !== exp_lat) $display("FAIL rst_recover_latency: got %0d exp %0d", obs_lat, exp_lat); else n_pass++;
    n_checks++; if (cipher_o !== aes128(k, p) || done_o !== 1'b1) $display("FAIL rst_recover_cipher: got %h exp %h", cipher_o, aes128(k, p)); else n_pass++;
    delay_mask_i = 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    init_sbox;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick;
    test_reset;
    test_fips;
    test_random_ops;
`ifdef RANDOM_DELAY_EN
    test_lfsr_seq;
    test_mask_zero;
`endif
    test_start_ignored;
    test_wait_timeout;
    test_run_timeout;
    test_back_to_back;
    test_reset_midrun;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
